// File: rtl/abus_dma.sv
// Single-channel word copy engine driving an abus_master through one-cycle
// read/write/abort order pulses; reports the outcome through status and irq.
module abus_dma #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 64,
  localparam int SK_SIZE   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  abus_clk,
  input  logic                  abus_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  irq,
  output logic [1:0]            status,
  output logic [LEN_WIDTH-1:0]  remaining,
  output logic                  write,
  output logic                  read,
  output logic                  abort,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [SK_SIZE-1:0]    strb,
  output logic [SK_SIZE-1:0]    keep,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  new_rdata,
  input  logic                  done,
  input  logic                  err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH} state_t;
  typedef enum logic [1:0] {ST_OK, ST_BUSERR, ST_TIMEOUT, ST_STOPPED} status_t;

  state_t                state_q, state_d;
  status_t               status_q, status_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  abort_q, abort_d;
  logic                  timed_out;

  assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge abus_clk or posedge abus_rst) begin
    if (abus_rst) begin
      state_q  <= IDLE;
      status_q <= ST_OK;
      src_q    <= '0;
      dst_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rem_q    <= '0;
      wait_q   <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    src_d    = src_q;
    dst_d    = dst_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          status_d = ST_OK;
          src_d    = src_addr;
          dst_d    = dst_addr;
          rem_d    = length;
          state_d  = (length == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        addr_d = (state_q == RD_REQ) ? src_q : dst_q;
        wait_d = '0;
        if (stop) begin
          abort_d  = 1'b1;
          status_d = ST_STOPPED;
          state_d  = FINISH;
        end else begin
          state_d = (state_q == RD_REQ) ? RD_WAIT : WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (state_q == RD_WAIT && new_rdata) data_d = rdata;
        // done/err outranks stop, which outranks the timeout
        if (done) begin
          if (err) begin
            status_d = ST_BUSERR;
            state_d  = FINISH;
          end else if (state_q == RD_WAIT) begin
            state_d = WR_REQ;
          end else begin
            rem_d   = rem_q - LEN_WIDTH'(1);
            src_d   = src_q + ADDR_WIDTH'(1);
            dst_d   = dst_q + ADDR_WIDTH'(1);
            state_d = (rem_q == LEN_WIDTH'(1)) ? FINISH : RD_REQ;
          end
        end else if (stop) begin
          abort_d  = 1'b1;
          status_d = ST_STOPPED;
          state_d  = FINISH;
        end else if (timed_out) begin
          abort_d  = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = FINISH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign read      = (state_q == RD_REQ);
  assign write     = (state_q == WR_REQ);
  assign abort     = abort_q;
  assign irq       = (state_q == FINISH);
  assign busy      = (state_q != IDLE);
  assign status    = status_q;
  assign remaining = rem_q;
  // Drive the live counter during an order, otherwise the last order address
  assign address   = read ? src_q : (write ? dst_q : addr_q);
  assign wdata     = data_q;
  assign strb      = '0;
  assign keep      = '1;

endmodule

// File: tb/tb_abus_dma.sv
// Scoreboard bench for abus_dma: a word-level copy model predicts the order
// stream and completion records; a memory slave model answers the orders.
module tb_abus_dma;
  localparam int AW = 16, DW = 16, LW = 8, TO = 64, SK = 5;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [AW-1:0] src_addr, dst_addr, address;
  logic [LW-1:0] length, remaining;
  logic          busy, irq, write, read, abort;
  logic [1:0]    status;
  logic [DW-1:0] wdata, rdata;
  logic [SK-1:0] strb, keep;
  logic          new_rdata, done, err;

  abus_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
    .abus_clk(clk), .abus_rst(rst), .start(start), .stop(stop),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .irq(irq), .status(status), .remaining(remaining),
    .write(write), .read(read), .abort(abort), .address(address),
    .wdata(wdata), .strb(strb), .keep(keep), .rdata(rdata),
    .new_rdata(new_rdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; } order_t;
  typedef struct { logic [1:0] st; logic [7:0] rem; bit ab; } comp_t;

  order_t      ord_q[$];
  comp_t       comp_q[$];
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          n_checks = 0, n_pass = 0;
  int          abort_gap = -1;
  bit          hold_rd = 0, hold_wr = 0;
  int          err_wr_idx = -1, wr_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Word-by-word copy model: predicts n_orders orders, commits the first
  // len-rem words to the reference memory, optionally queues a completion.
  task automatic expect_copy(input logic [15:0] s, input logic [15:0] d, input int len,
                             input int n_orders, input int rem, input logic [1:0] st,
                             input bit ab, input bit push_comp);
    int k = 0;
    order_t o;
    comp_t c;
    for (int i = 0; i < len; i++) begin
      logic [15:0] sa, da, v;
      sa = s + 16'(i);
      da = d + 16'(i);
      v  = ref_mem[sa];
      if (k < n_orders) begin o.wr = 0; o.addr = sa; o.data = 0; ord_q.push_back(o); k++; end
      if (k < n_orders) begin o.wr = 1; o.addr = da; o.data = v; ord_q.push_back(o); k++; end
      if (i < len - rem) ref_mem[da] = v;
    end
    if (push_comp) begin
      c.st = st; c.rem = 8'(rem); c.ab = ab;
      comp_q.push_back(c);
    end
  endtask

  // Memory slave: answers each order after 1..3 cycles unless held back
  initial begin
    bit pend, pwr;
    int cnt, widx;
    logic [15:0] paddr, pdata;
    pend = 0; pwr = 0; cnt = 0; widx = 0; paddr = 0; pdata = 0;
    done = 0; new_rdata = 0; err = 0; rdata = 0;
    forever begin
      @(negedge clk);
      done = 0; new_rdata = 0; err = 0; rdata = 16'($urandom);
      if (rst || abort) pend = 0;
      else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 0;
            done = 1;
            if (!pwr) begin new_rdata = 1; rdata = mem[paddr]; end
            else if (widx == err_wr_idx) err = 1;
            else mem[paddr] = pdata;
          end
        end
        if (read) begin
          pwr = 0; paddr = address; pend = !hold_rd; cnt = int'($urandom_range(1, 3));
        end
        if (write) begin
          pwr = 1; paddr = address; pdata = wdata; widx = wr_count; wr_count++;
          pend = !hold_wr; cnt = int'($urandom_range(1, 3));
        end
      end
    end
  end

  // Monitor: pops and compares on every order pulse and every irq
  initial begin
    int cyc, last_ord;
    bit irq_prev;
    order_t e;
    comp_t c;
    cyc = 0; last_ord = 0; irq_prev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (read || write || abort)
          chk("order_exclusive", 32'(read) + 32'(write) + 32'(abort), 1);
        if (read || write) begin
          if (ord_q.size() == 0) chk("unexpected_order", {30'd0, read, write}, 0);
          else begin
            e = ord_q.pop_front();
            chk("order_kind", 32'(write), 32'(e.wr));
            chk("order_addr", address, e.addr);
            if (write) chk("order_wdata", wdata, e.data);
          end
          last_ord = cyc;
        end
        if (abort) abort_gap = cyc - last_ord;
        if (irq) begin
          chk("irq_single_cycle", 32'(irq_prev), 0);
          if (comp_q.size() == 0) chk("unexpected_irq", 32'(irq), 0);
          else begin
            c = comp_q.pop_front();
            chk("done_status", status, c.st);
            chk("done_remaining", remaining, c.rem);
            chk("done_abort", 32'(abort), 32'(c.ab));
          end
        end
        irq_prev = irq;
      end else irq_prev = 0;
    end
  end

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] len);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = len; start = 1; wr_count = 0;
    @(negedge clk);
    start = 0; src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 8'($urandom);
    if (len == 0) chk("len0_irq_next_cycle", 32'(irq), 1);
    else chk("busy_after_start", 32'(busy), 1);
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n = 0;
    while (!irq && n < budget) begin @(negedge clk); n++; end
    chk({name, "_irq_seen"}, 32'(irq), 1);
    @(negedge clk);
    chk({name, "_busy_low_after_irq"}, 32'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_irq"}, 32'(irq), 0);
    chk({name, "_read"}, 32'(read), 0);
    chk({name, "_write"}, 32'(write), 0);
    chk({name, "_abort"}, 32'(abort), 0);
    chk({name, "_status"}, status, 0);
    chk({name, "_remaining"}, remaining, 0);
    chk({name, "_address"}, address, 0);
    chk({name, "_wdata"}, wdata, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat [4];
    int n;
    pat[0] = 16'hCAFE; pat[1] = 16'hBEEF; pat[2] = 16'h1234; pat[3] = 16'h5678;
    rst = 1; start = 0; stop = 0; src_addr = 0; dst_addr = 0; length = 0;
    for (int i = 0; i < 65536; i++) begin mem[i] = 16'($urandom); ref_mem[i] = mem[i]; end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("strb_zero", strb, 0);
    chk("keep_ones", keep, 32'h1F);
    rst = 0;

    // Four-word copy, with a start pulse that must be ignored mid-transfer
    for (int i = 0; i < 4; i++) begin mem[16'h0100 + i] = pat[i]; ref_mem[16'h0100 + i] = pat[i]; end
    expect_copy(16'h0100, 16'h0180, 4, 8, 0, 2'd0, 0, 1);
    pulse_start(16'h0100, 16'h0180, 8'd4);
    repeat (2) @(negedge clk);
    start = 1; length = 0;
    @(negedge clk);
    start = 0;
    wait_irq("copy4", 200);
    for (int i = 0; i < 4; i++) chk("copy4_dst_word", mem[16'h0180 + i], pat[i]);

    expect_copy(16'h0300, 16'h0400, 0, 0, 0, 2'd0, 0, 1);
    pulse_start(16'h0300, 16'h0400, 8'd0);
    wait_irq("len0", 5);

    expect_copy(16'hFFFF, 16'h0010, 2, 4, 0, 2'd0, 0, 1);
    pulse_start(16'hFFFF, 16'h0010, 8'd2);
    wait_irq("wrap", 100);

    err_wr_idx = 0;
    expect_copy(16'h0200, 16'h0280, 2, 2, 2, 2'd1, 0, 1);
    pulse_start(16'h0200, 16'h0280, 8'd2);
    wait_irq("buserr", 100);
    repeat (10) @(negedge clk);
    err_wr_idx = -1;

    hold_rd = 1; abort_gap = -1;
    expect_copy(16'h0500, 16'h0600, 3, 1, 3, 2'd2, 1, 1);
    pulse_start(16'h0500, 16'h0600, 8'd3);
    wait_irq("timeout", 200);
    chk("timeout_abort_gap", abort_gap, TO + 1);

    expect_copy(16'h0700, 16'h0710, 2, 1, 2, 2'd3, 1, 1);
    pulse_start(16'h0700, 16'h0710, 8'd2);
    repeat (2) @(negedge clk);
    stop = 1;
    @(negedge clk);
    stop = 0;
    wait_irq("stop", 10);
    hold_rd = 0;
    stop = 1;
    @(negedge clk);
    stop = 0;
    chk("idle_stop_abort", 32'(abort), 0);
    chk("idle_stop_busy", 32'(busy), 0);
    chk("idle_stop_status_held", status, 3);

    // Reset while the write is outstanding
    hold_wr = 1;
    mem[16'h0800] = 16'hA5A5; ref_mem[16'h0800] = 16'hA5A5;
    expect_copy(16'h0800, 16'h0900, 1, 2, 1, 2'd0, 0, 0);
    pulse_start(16'h0800, 16'h0900, 8'd1);
    n = 0;
    while (!write && n < 20) begin @(negedge clk); n++; end
    chk("rst_test_write_seen", 32'(write), 1);
    @(negedge clk);
    #2 rst = 1;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst = 0; hold_wr = 0;
    expect_copy(16'h0810, 16'h0910, 1, 2, 0, 2'd0, 0, 1);
    pulse_start(16'h0810, 16'h0910, 8'd1);
    wait_irq("after_reset", 100);

    for (int r = 0; r < 20; r++) begin
      logic [15:0] s, d;
      int len;
      s = 16'($urandom); d = 16'($urandom); len = int'($urandom_range(0, 6));
      expect_copy(s, d, len, 2 * len, 0, 2'd0, 0, 1);
      pulse_start(s, d, 8'(len));
      wait_irq("random", 300);
    end

    repeat (5) @(negedge clk);
    chk("orders_drained", ord_q.size(), 0);
    chk("completions_drained", comp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
